// File: rtl/eth_evt_collect.sv
// Debounced rising-event collector: filters a synchronized level, counts qualified rising
// events with saturation, and raises sticky pending/overflow flags with a maskable irq.
module eth_evt_collect #(
  parameter int unsigned FILT  = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync_in,
  input  logic             clr,
  input  logic             mask,
  output logic             evt_pulse,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             pending,
  output logic             overflow,
  output logic             irq
);

  localparam logic [3:0]       FiltQ  = 4'(FILT);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [1:0] {
    StLow,
    StRise,
    StHigh,
    StFall
  } state_e;

  state_e     state;
  logic [3:0] qcnt;
  logic [3:0] qcnt_inc;
  logic       fire;

  assign qcnt_inc = qcnt + 4'd1;

  // Only qualification from the low side produces an event; FALL -> HIGH never fires.
  always_comb begin
    fire = 1'b0;
    if (sync_in) begin
      if ((state == StLow) && (FiltQ == 4'd1)) fire = 1'b1;
      if ((state == StRise) && (qcnt_inc == FiltQ)) fire = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StLow;
      qcnt      <= 4'd0;
      evt_pulse <= 1'b0;
      evt_cnt   <= '0;
      pending   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      evt_pulse <= fire;

      case (state)
        StLow: begin
          if (sync_in) begin
            if (FiltQ == 4'd1) begin
              state <= StHigh;
              qcnt  <= 4'd0;
            end else begin
              state <= StRise;
              qcnt  <= 4'd1;
            end
          end
        end
        StRise: begin
          if (sync_in) begin
            if (qcnt_inc == FiltQ) begin
              state <= StHigh;
              qcnt  <= 4'd0;
            end else begin
              qcnt <= qcnt_inc;
            end
          end else begin
            state <= StLow;
            qcnt  <= 4'd0;
          end
        end
        StHigh: begin
          if (!sync_in) begin
            if (FiltQ == 4'd1) begin
              state <= StLow;
              qcnt  <= 4'd0;
            end else begin
              state <= StFall;
              qcnt  <= 4'd1;
            end
          end
        end
        StFall: begin
          if (!sync_in) begin
            if (qcnt_inc == FiltQ) begin
              state <= StLow;
              qcnt  <= 4'd0;
            end else begin
              qcnt <= qcnt_inc;
            end
          end else begin
            state <= StHigh;
            qcnt  <= 4'd0;
          end
        end
        default: begin
          state <= StLow;
          qcnt  <= 4'd0;
        end
      endcase

      // A coincident event beats clr: the cleared count restarts at one.
      if (fire) begin
        pending <= 1'b1;
        if (clr) begin
          evt_cnt  <= CntOne;
          overflow <= 1'b0;
        end else if (evt_cnt == CntMax) begin
          overflow <= 1'b1;
        end else begin
          evt_cnt <= evt_cnt + CntOne;
        end
      end else if (clr) begin
        evt_cnt  <= '0;
        pending  <= 1'b0;
        overflow <= 1'b0;
      end
    end
  end

  assign irq = pending & ~mask;

endmodule

// File: tb/tb_eth_evt_collect.sv
// Directed bench for eth_evt_collect: three instances cover FILT=2/CNT_W=4, FILT=3 and FILT=1.
module tb_eth_evt_collect;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       mask;
  logic       sync_a, sync_b, sync_c;
  logic       pulse_a, pulse_b, pulse_c;
  logic [3:0] cnt_a;
  logic [7:0] cnt_b, cnt_c;
  logic       pend_a, pend_b, pend_c;
  logic       ovf_a, ovf_b, ovf_c;
  logic       irq_a, irq_b, irq_c;

  int n_vec = 0;
  int n_err = 0;

  eth_evt_collect #(.FILT(2), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .sync_in(sync_a), .clr(clr), .mask(mask),
    .evt_pulse(pulse_a), .evt_cnt(cnt_a), .pending(pend_a), .overflow(ovf_a), .irq(irq_a)
  );

  eth_evt_collect #(.FILT(3), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .sync_in(sync_b), .clr(clr), .mask(mask),
    .evt_pulse(pulse_b), .evt_cnt(cnt_b), .pending(pend_b), .overflow(ovf_b), .irq(irq_b)
  );

  eth_evt_collect #(.FILT(1), .CNT_W(8)) dut_c (
    .clk(clk), .reset(reset), .sync_in(sync_c), .clr(clr), .mask(mask),
    .evt_pulse(pulse_c), .evt_cnt(cnt_c), .pending(pend_c), .overflow(ovf_c), .irq(irq_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One qualified event on dut_a: two high samples, then two low samples back to LOW.
  task automatic fire_a();
    sync_a = 1'b1;
    tick();
    tick();
    sync_a = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; clr = 1'b0; mask = 1'b0;
    sync_a = 1'b0; sync_b = 1'b0; sync_c = 1'b0;
    #3;
    chk("rst_pulse", pulse_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_pend", pend_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_irq", irq_a, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // FILT=2 basic event, held high 5 cycles
    sync_a = 1'b1;
    tick();
    chk("f2_first_pulse", pulse_a, 0);
    chk("f2_first_cnt", cnt_a, 0);
    tick();
    chk("f2_fire_pulse", pulse_a, 1);
    chk("f2_fire_cnt", cnt_a, 1);
    chk("f2_fire_pend", pend_a, 1);
    chk("f2_fire_irq", irq_a, 1);
    tick();
    chk("f2_pulse_one_cycle", pulse_a, 0);
    tick();
    tick();
    chk("f2_held_cnt", cnt_a, 1);
    sync_a = 1'b0;
    tick();
    tick();

    // mask acts on irq combinationally only
    mask = 1'b1;
    #1;
    chk("mask_irq", irq_a, 0);
    chk("mask_pend", pend_a, 1);
    mask = 1'b0;
    #1;
    chk("unmask_irq", irq_a, 1);

    // single-cycle glitch rejected
    sync_a = 1'b1;
    tick();
    sync_a = 1'b0;
    tick();
    chk("glitch_pulse", pulse_a, 0);
    tick();
    chk("glitch_cnt", cnt_a, 1);

    // clr alone, then nine events, then clr coincident with the tenth
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_cnt", cnt_a, 0);
    chk("clr_pend", pend_a, 0);
    chk("clr_irq", irq_a, 0);
    for (int i = 0; i < 9; i++) fire_a();
    chk("nine_cnt", cnt_a, 9);
    sync_a = 1'b1;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_fire_pulse", pulse_a, 1);
    chk("clr_fire_cnt", cnt_a, 1);
    chk("clr_fire_pend", pend_a, 1);
    chk("clr_fire_ovf", ovf_a, 0);
    sync_a = 1'b0;
    tick();
    tick();

    // saturation at 15 with CNT_W=4
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 15; i++) fire_a();
    chk("sat15_cnt", cnt_a, 15);
    chk("sat15_ovf", ovf_a, 0);
    fire_a();
    chk("sat16_cnt", cnt_a, 15);
    chk("sat16_ovf", ovf_a, 1);
    fire_a();
    chk("sat17_cnt", cnt_a, 15);
    chk("sat17_ovf", ovf_a, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("satclr_cnt", cnt_a, 0);
    chk("satclr_ovf", ovf_a, 0);
    chk("satclr_pend", pend_a, 0);

    // async reset while the pulse is high, sync_in held high across release
    sync_a = 1'b1;
    tick();
    tick();
    chk("pre_rst_pulse", pulse_a, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pulse", pulse_a, 0);
    chk("async_rst_cnt", cnt_a, 0);
    chk("async_rst_pend", pend_a, 0);
    chk("async_rst_irq", irq_a, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("held_rel1_pulse", pulse_a, 0);
    chk("held_rel1_cnt", cnt_a, 0);
    tick();
    chk("held_rel2_pulse", pulse_a, 1);
    chk("held_rel2_cnt", cnt_a, 1);
    sync_a = 1'b0;
    tick();
    tick();

    // reset mid-RISE discards the partial qualification
    sync_a = 1'b1;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("midrise_cnt", cnt_a, 0);
    chk("midrise_pend", pend_a, 0);
    chk("midrise_pulse", pulse_a, 0);
    sync_a = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sync_a = 1'b1;
    tick();
    chk("midrise_rel1_pulse", pulse_a, 0);
    chk("midrise_rel1_cnt", cnt_a, 0);
    tick();
    chk("midrise_rel2_pulse", pulse_a, 1);
    chk("midrise_rel2_cnt", cnt_a, 1);
    sync_a = 1'b0;
    tick();
    tick();

    // FILT=3: two high samples is a glitch; one-cycle low bounce in HIGH adds nothing
    sync_b = 1'b1;
    tick();
    chk("f3_g1_pulse", pulse_b, 0);
    tick();
    chk("f3_g2_pulse", pulse_b, 0);
    sync_b = 1'b0;
    tick();
    chk("f3_g3_pulse", pulse_b, 0);
    tick();
    chk("f3_glitch_cnt", cnt_b, 0);
    sync_b = 1'b1;
    tick();
    tick();
    chk("f3_q2_pulse", pulse_b, 0);
    tick();
    chk("f3_fire_pulse", pulse_b, 1);
    chk("f3_fire_cnt", cnt_b, 1);
    sync_b = 1'b0;
    tick();
    sync_b = 1'b1;
    tick();
    chk("f3_bounce1_pulse", pulse_b, 0);
    tick();
    chk("f3_bounce2_pulse", pulse_b, 0);
    chk("f3_bounce_cnt", cnt_b, 1);

    // FILT=1: fires on the first high sample, consecutive fires give separate pulses
    sync_c = 1'b1;
    tick();
    chk("f1_fire1_pulse", pulse_c, 1);
    chk("f1_fire1_cnt", cnt_c, 1);
    sync_c = 1'b0;
    tick();
    chk("f1_low_pulse", pulse_c, 0);
    sync_c = 1'b1;
    tick();
    chk("f1_fire2_pulse", pulse_c, 1);
    chk("f1_fire2_cnt", cnt_c, 2);
    tick();
    chk("f1_held_pulse", pulse_c, 0);
    chk("f1_held_cnt", cnt_c, 2);
    chk("f1_irq", irq_c, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
